// File: rtl/router_sta.sv
// rtl/router_sta.sv - registered XY route computation for one node of a 2x4 mesh NoC.
// Address: x = addr[1:0] (column, 0 = west), y = addr[2] (row, 0 = north).
module router_sta (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] router_add,
  input  logic [2:0] dst,
  output logic [2:0] port
);

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'b000,
    PORT_NORTH = 3'b001,
    PORT_EAST  = 3'b010,
    PORT_SOUTH = 3'b011,
    PORT_WEST  = 3'b100
  } port_e;

  logic [1:0] cur_x, dst_x;
  logic       cur_y, dst_y;
  port_e      port_d, port_q;

  assign cur_x = router_add[1:0];
  assign cur_y = router_add[2];
  assign dst_x = dst[1:0];
  assign dst_y = dst[2];

  // X is resolved completely before Y, which keeps routing deadlock-free.
  always_comb begin
    port_d = PORT_LOCAL;
    if (dst_x > cur_x) begin
      port_d = PORT_EAST;
    end else if (dst_x < cur_x) begin
      port_d = PORT_WEST;
    end else if (dst_y > cur_y) begin
      port_d = PORT_SOUTH;
    end else if (dst_y < cur_y) begin
      port_d = PORT_NORTH;
    end
  end

  // rst_n is asserted high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      port_q <= PORT_LOCAL;
    end else if (en) begin
      port_q <= port_d;
    end
  end

  assign port = port_q;

endmodule

// File: tb/tb_router_sta.sv
// tb/tb_router_sta.sv - scoreboard bench for router_sta.
module tb_router_sta;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] router_add;
  logic [2:0] dst;
  logic [2:0] port;

  int         n_tests;
  int         n_failed;
  logic [2:0] model;
  logic [2:0] sb[$];

  router_sta dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .router_add(router_add),
    .dst       (dst),
    .port      (port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference XY rule using signed coordinate deltas.
  function automatic logic [2:0] route(input logic [2:0] ra, input logic [2:0] d);
    int dx;
    int dy;
    dx = int'(d[1:0]) - int'(ra[1:0]);
    dy = int'(d[2]) - int'(ra[2]);
    if (dx > 0)      return 3'b010;
    else if (dx < 0) return 3'b100;
    else if (dy > 0) return 3'b011;
    else if (dy < 0) return 3'b001;
    else             return 3'b000;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] ra, input logic [2:0] d, input logic e, input string tag);
    @(negedge clk);
    router_add = ra;
    dst        = d;
    en         = e;
    if (rst_n) model = 3'b000;
    else if (e) model = route(ra, d);
    sb.push_back(model);
    @(posedge clk);
    #1;
    check(tag, port, sb.pop_front());
  endtask

  initial begin
    n_tests    = 0;
    n_failed   = 0;
    model      = 3'b000;
    rst_n      = 1'b1;
    en         = 1'b1;
    router_add = 3'b000;
    dst        = 3'b011;
    #1;
    check("reset_async_start", port, 3'b000);

    step(3'b000, 3'b011, 1'b1, "reset_hold_en0");
    step(3'b011, 3'b100, 1'b1, "reset_hold_en1");
    step(3'b110, 3'b001, 1'b1, "reset_hold_en2");

    @(negedge clk);
    rst_n = 1'b0;
    step(3'b000, 3'b011, 1'b1, "east_first_after_reset");
    step(3'b011, 3'b100, 1'b1, "west_x_wins");
    step(3'b001, 3'b101, 1'b1, "south");
    step(3'b110, 3'b010, 1'b1, "north");
    step(3'b101, 3'b101, 1'b1, "local");

    step(3'b000, 3'b111, 1'b1, "en_load_east");
    step(3'b000, 3'b000, 1'b0, "en_hold_1");
    step(3'b000, 3'b000, 1'b0, "en_hold_2");
    step(3'b000, 3'b000, 1'b1, "en_reraise_local");

    step(3'b011, 3'b000, 1'b1, "pre_midreset_west");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    model = 3'b000;
    #1;
    check("midreset_async_clear", port, 3'b000);
    step(3'b000, 3'b010, 1'b1, "midreset_hold");
    @(negedge clk);
    rst_n = 1'b0;
    step(3'b100, 3'b000, 1'b1, "post_midreset_fresh");

    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < 8; d++) begin
        step(3'(r), 3'(d), 1'b1, $sformatf("sweep_r%0d_d%0d_a", r, d));
        step(3'(r), 3'(d), 1'b1, $sformatf("sweep_r%0d_d%0d_b", r, d));
        n_tests++;
        assert (port <= 3'b100) else begin
          n_failed++;
          $error("FAIL sweep_code_range_r%0d_d%0d observed=%b expected<=100", r, d, port);
        end
      end
    end

    n_tests++;
    assert (sb.size() == 0) else begin
      n_failed++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
